// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL power-up / lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is visible on the STATE debug port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POWER_UP = 3'd1,
    ST_STABLE   = 3'd2,
    ST_ENABLE   = 3'd3,
    ST_RUN      = 3'd4,
    ST_OFF      = 3'd5,
    ST_FAULT    = 3'd6
  } pll_state_e;

  localparam int NUM_OUTS = 4;

  // Retry counter width and the value it sticks at.
  localparam int                RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = 4'd15;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for an asynchronous PLL status line; clears to 0 on reset.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_p0;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0  <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_p0  <= async_in;
      sync_out <= meta_p0;
    end
  end

endmodule

// File: rtl/pll_sequencer.sv
// PLL bring-up sequencer: powers the PLL, qualifies lock, releases output
// clocks in staggered slots, and power-cycles the PLL on lock loss with a
// bounded number of retries before reporting FAULT.
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT       = 4096,
  parameter int OUT_STAGGER        = 4,
  parameter int OFF_CYCLES         = 8,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [NUM_OUTS-1:0] OUT_EN_MASK,
  input  logic                PLL_LOCK,
  output logic                PLL_EN,
  output logic [NUM_OUTS-1:0] CLK_OUT_EN,
  output logic                READY,
  output logic                FAULT,
  output logic [RETRY_W-1:0]  RETRY_CNT,
  output logic [2:0]          STATE
);

  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SC_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int STG_W = $clog2(OUT_STAGGER) + 1;
  localparam int OFF_W = $clog2(OFF_CYCLES) + 1;

  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SC_W-1:0]    STAB_DONE = SC_W'(LOCK_STABLE_CYCLES);
  localparam logic [STG_W-1:0]   STG_LAST  = STG_W'(OUT_STAGGER - 1);
  localparam logic [OFF_W-1:0]   OFF_LAST  = OFF_W'(OFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);

  // Increment that holds at the top value instead of wrapping.
  function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
    return (cnt == RETRY_SAT) ? cnt : cnt + RETRY_W'(1);
  endfunction

  pll_state_e          state;
  logic                lock_s;
  logic [NUM_OUTS-1:0] mask_q;
  logic [TO_W-1:0]     to_cnt;
  logic [SC_W-1:0]     stab_cnt;
  logic [STG_W-1:0]    stg_cnt;
  logic [1:0]          slot;
  logic [OFF_W-1:0]    off_cnt;
  logic [RETRY_W-1:0]  retry_nxt;
  logic                retry_over;
  logic                enter_off;

  pll_lock_sync u_lock_sync (
    .clk      (CLK),
    .rst      (RST),
    .async_in (PLL_LOCK),
    .sync_out (lock_s)
  );

  assign STATE = state;

  // Power-cycle trigger: lock timeout while powering up, or lock lost once outputs are live.
  always_comb begin
    retry_nxt  = retry_sat_inc(RETRY_CNT);
    retry_over = (retry_nxt > RETRY_LIM);
    enter_off  = 1'b0;
    if ((state == ST_POWER_UP) && !lock_s && (to_cnt == TO_LAST))
      enter_off = 1'b1;
    if (((state == ST_ENABLE) || (state == ST_RUN)) && !lock_s)
      enter_off = 1'b1;
  end

  // Sequencer FSM with registered outputs; counters are loaded on state entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      PLL_EN     <= 1'b0;
      CLK_OUT_EN <= '0;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
      RETRY_CNT  <= '0;
    end else if (!START) begin
      state      <= ST_IDLE;
      PLL_EN     <= 1'b0;
      CLK_OUT_EN <= '0;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
      RETRY_CNT  <= '0;
    end else if (enter_off) begin
      // Exhausting the retry budget goes straight to FAULT rather than through OFF.
      PLL_EN     <= 1'b0;
      CLK_OUT_EN <= '0;
      READY      <= 1'b0;
      RETRY_CNT  <= retry_nxt;
      off_cnt    <= '0;
      if (retry_over) begin
        state <= ST_FAULT;
        FAULT <= 1'b1;
      end else begin
        state <= ST_OFF;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          mask_q    <= OUT_EN_MASK;
          RETRY_CNT <= '0;
          PLL_EN    <= 1'b1;
          to_cnt    <= '0;
          state     <= ST_POWER_UP;
        end
        ST_POWER_UP: begin
          if (lock_s) begin
            stab_cnt <= SC_W'(1);
            state    <= ST_STABLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_STABLE: begin
          // A lock drop here re-qualifies from scratch without spending a retry.
          if (!lock_s) begin
            to_cnt <= '0;
            state  <= ST_POWER_UP;
          end else if (stab_cnt == STAB_DONE) begin
            slot          <= 2'd0;
            stg_cnt       <= '0;
            CLK_OUT_EN[0] <= mask_q[0];
            state         <= ST_ENABLE;
          end else begin
            stab_cnt <= stab_cnt + SC_W'(1);
          end
        end
        ST_ENABLE: begin
          // Every slot takes its full time, even when its mask bit is clear.
          if (stg_cnt == STG_LAST) begin
            stg_cnt <= '0;
            if (slot == 2'd3) begin
              READY     <= 1'b1;
              RETRY_CNT <= '0;
              state     <= ST_RUN;
            end else begin
              slot                      <= slot + 2'd1;
              CLK_OUT_EN[slot + 2'd1]   <= mask_q[slot + 2'd1];
            end
          end else begin
            stg_cnt <= stg_cnt + STG_W'(1);
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        ST_OFF: begin
          if (off_cnt == OFF_LAST) begin
            PLL_EN <= 1'b1;
            to_cnt <= '0;
            state  <= ST_POWER_UP;
          end else begin
            off_cnt <= off_cnt + OFF_W'(1);
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with small timing parameters.
module tb_pll_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] OUT_EN_MASK;
  logic       PLL_LOCK;
  logic       PLL_EN;
  logic [3:0] CLK_OUT_EN;
  logic       READY;
  logic       FAULT;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  int n_chk  = 0;
  int n_fail = 0;

  pll_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT       (32),
    .OUT_STAGGER        (2),
    .OFF_CYCLES         (4),
    .MAX_RETRIES        (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .OUT_EN_MASK (OUT_EN_MASK),
    .PLL_LOCK    (PLL_LOCK),
    .PLL_EN      (PLL_EN),
    .CLK_OUT_EN  (CLK_OUT_EN),
    .READY       (READY),
    .FAULT       (FAULT),
    .RETRY_CNT   (RETRY_CNT),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; PLL_LOCK = 1'b0; OUT_EN_MASK = 4'b0000;
    tick(2);
    n_chk++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", STATE); end
    n_chk++; if (PLL_EN !== 1'b0) begin n_fail++; $display("FAIL reset_pll_en got %0b exp 0", PLL_EN); end
    n_chk++; if (CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL reset_clk_out_en got %b exp 0000", CLK_OUT_EN); end
    n_chk++; if (READY !== 1'b0 || FAULT !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fault got %0b%0b exp 00", READY, FAULT); end
    n_chk++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL reset_retry got %0d exp 0", RETRY_CNT); end
    RST = 1'b0;
    tick(1);
    n_chk++; if (STATE !== 3'd0) begin n_fail++; $display("FAIL idle_hold got %0d exp 0", STATE); end
  endtask

  task automatic test_nominal;
    OUT_EN_MASK = 4'b1011; START = 1'b1;
    tick(1);
    n_chk++; if (STATE !== 3'd1 || PLL_EN !== 1'b1) begin n_fail++; $display("FAIL nom_power_up got st=%0d en=%0b exp st=1 en=1", STATE, PLL_EN); end
    tick(5);
    PLL_LOCK = 1'b1;
    tick(2);
    n_chk++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL nom_sync_lag got %0d exp 1", STATE); end
    tick(8);
    n_chk++; if (STATE !== 3'd2 || CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL nom_stable_end got st=%0d en=%b exp st=2 en=0000", STATE, CLK_OUT_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd3 || CLK_OUT_EN !== 4'b0001) begin n_fail++; $display("FAIL nom_slot0 got st=%0d en=%b exp st=3 en=0001", STATE, CLK_OUT_EN); end
    tick(2);
    n_chk++; if (CLK_OUT_EN !== 4'b0011) begin n_fail++; $display("FAIL nom_slot1 got %b exp 0011", CLK_OUT_EN); end
    tick(2);
    n_chk++; if (CLK_OUT_EN !== 4'b0011) begin n_fail++; $display("FAIL nom_slot2_silent got %b exp 0011", CLK_OUT_EN); end
    tick(2);
    n_chk++; if (CLK_OUT_EN !== 4'b1011) begin n_fail++; $display("FAIL nom_slot3 got %b exp 1011", CLK_OUT_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd3 || READY !== 1'b0) begin n_fail++; $display("FAIL nom_slot3_tail got st=%0d rdy=%0b exp st=3 rdy=0", STATE, READY); end
    tick(1);
    n_chk++; if (STATE !== 3'd4 || READY !== 1'b1) begin n_fail++; $display("FAIL nom_run got st=%0d rdy=%0b exp st=4 rdy=1", STATE, READY); end
    n_chk++; if (RETRY_CNT !== 4'd0 || FAULT !== 1'b0 || PLL_EN !== 1'b1) begin n_fail++; $display("FAIL nom_run_flags got rc=%0d flt=%0b en=%0b exp 0 0 1", RETRY_CNT, FAULT, PLL_EN); end
  endtask

  task automatic test_lock_loss_run;
    PLL_LOCK = 1'b0;
    tick(2);
    n_chk++; if (STATE !== 3'd4 || CLK_OUT_EN !== 4'b1011) begin n_fail++; $display("FAIL loss_lag got st=%0d en=%b exp st=4 en=1011", STATE, CLK_OUT_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd5 || CLK_OUT_EN !== 4'b0000 || READY !== 1'b0) begin n_fail++; $display("FAIL loss_gate got st=%0d en=%b rdy=%0b exp st=5 en=0000 rdy=0", STATE, CLK_OUT_EN, READY); end
    n_chk++; if (PLL_EN !== 1'b0 || RETRY_CNT !== 4'd1) begin n_fail++; $display("FAIL loss_off got en=%0b rc=%0d exp en=0 rc=1", PLL_EN, RETRY_CNT); end
    PLL_LOCK = 1'b1;
    tick(3);
    n_chk++; if (STATE !== 3'd5 || PLL_EN !== 1'b0) begin n_fail++; $display("FAIL loss_off_last got st=%0d en=%0b exp st=5 en=0", STATE, PLL_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd1 || PLL_EN !== 1'b1) begin n_fail++; $display("FAIL loss_repower got st=%0d en=%0b exp st=1 en=1", STATE, PLL_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL loss_restable got %0d exp 2", STATE); end
    tick(15);
    n_chk++; if (STATE !== 3'd3 || RETRY_CNT !== 4'd1 || CLK_OUT_EN !== 4'b1011) begin n_fail++; $display("FAIL loss_reenable got st=%0d rc=%0d en=%b exp st=3 rc=1 en=1011", STATE, RETRY_CNT, CLK_OUT_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd4 || RETRY_CNT !== 4'd0 || READY !== 1'b1) begin n_fail++; $display("FAIL loss_rerun got st=%0d rc=%0d rdy=%0b exp st=4 rc=0 rdy=1", STATE, RETRY_CNT, READY); end
  endtask

  task automatic test_glitch_stable;
    START = 1'b0; PLL_LOCK = 1'b0;
    tick(3);
    n_chk++; if (STATE !== 3'd0 || PLL_EN !== 1'b0) begin n_fail++; $display("FAIL glitch_idle got st=%0d en=%0b exp st=0 en=0", STATE, PLL_EN); end
    OUT_EN_MASK = 4'b1111; START = 1'b1;
    tick(1);
    PLL_LOCK = 1'b1;
    tick(6);
    n_chk++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL glitch_stable got %0d exp 2", STATE); end
    PLL_LOCK = 1'b0;
    tick(3);
    n_chk++; if (STATE !== 3'd1 || RETRY_CNT !== 4'd0 || CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL glitch_back got st=%0d rc=%0d en=%b exp st=1 rc=0 en=0000", STATE, RETRY_CNT, CLK_OUT_EN); end
    PLL_LOCK = 1'b1;
    tick(3);
    n_chk++; if (STATE !== 3'd2) begin n_fail++; $display("FAIL glitch_requal got %0d exp 2", STATE); end
    for (int i = 0; i < 7; i++) begin
      tick(1);
      n_chk++; if (CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL glitch_early_en cyc %0d got %b exp 0000", i, CLK_OUT_EN); end
    end
    tick(1);
    n_chk++; if (STATE !== 3'd3 || CLK_OUT_EN !== 4'b0001) begin n_fail++; $display("FAIL glitch_enable got st=%0d en=%b exp st=3 en=0001", STATE, CLK_OUT_EN); end
  endtask

  task automatic test_abort_enable;
    START = 1'b0;
    tick(1);
    n_chk++; if (STATE !== 3'd0 || PLL_EN !== 1'b0 || CLK_OUT_EN !== 4'b0000 || READY !== 1'b0) begin n_fail++; $display("FAIL abort got st=%0d en=%0b oe=%b rdy=%0b exp 0 0 0000 0", STATE, PLL_EN, CLK_OUT_EN, READY); end
  endtask

  task automatic test_timeout_fault;
    PLL_LOCK = 1'b0;
    tick(3);
    START = 1'b1;
    tick(1);
    tick(31);
    n_chk++; if (STATE !== 3'd1 || PLL_EN !== 1'b1) begin n_fail++; $display("FAIL to_last_pu got st=%0d en=%0b exp st=1 en=1", STATE, PLL_EN); end
    tick(1);
    n_chk++; if (STATE !== 3'd5 || RETRY_CNT !== 4'd1 || PLL_EN !== 1'b0) begin n_fail++; $display("FAIL to_off1 got st=%0d rc=%0d en=%0b exp 5 1 0", STATE, RETRY_CNT, PLL_EN); end
    tick(4);
    n_chk++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL to_pu2 got %0d exp 1", STATE); end
    tick(32);
    n_chk++; if (STATE !== 3'd5 || RETRY_CNT !== 4'd2) begin n_fail++; $display("FAIL to_off2 got st=%0d rc=%0d exp 5 2", STATE, RETRY_CNT); end
    tick(4);
    n_chk++; if (STATE !== 3'd1) begin n_fail++; $display("FAIL to_pu3 got %0d exp 1", STATE); end
    tick(31);
    n_chk++; if (STATE !== 3'd1 || FAULT !== 1'b0) begin n_fail++; $display("FAIL to_pu3_last got st=%0d flt=%0b exp 1 0", STATE, FAULT); end
    tick(1);
    n_chk++; if (STATE !== 3'd6 || FAULT !== 1'b1 || RETRY_CNT !== 4'd3) begin n_fail++; $display("FAIL to_fault got st=%0d flt=%0b rc=%0d exp 6 1 3", STATE, FAULT, RETRY_CNT); end
    n_chk++; if (PLL_EN !== 1'b0 || CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL to_fault_outs got en=%0b oe=%b exp 0 0000", PLL_EN, CLK_OUT_EN); end
    tick(5);
    n_chk++; if (STATE !== 3'd6 || FAULT !== 1'b1) begin n_fail++; $display("FAIL to_fault_hold got st=%0d flt=%0b exp 6 1", STATE, FAULT); end
    START = 1'b0;
    tick(1);
    n_chk++; if (STATE !== 3'd0 || FAULT !== 1'b0 || RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL to_clear got st=%0d flt=%0b rc=%0d exp 0 0 0", STATE, FAULT, RETRY_CNT); end
  endtask

  task automatic test_reset_run;
    PLL_LOCK = 1'b1; OUT_EN_MASK = 4'b0110;
    tick(3);
    START = 1'b1;
    tick(1);
    tick(9);
    n_chk++; if (STATE !== 3'd3 || CLK_OUT_EN !== 4'b0000) begin n_fail++; $display("FAIL rr_slot0 got st=%0d en=%b exp 3 0000", STATE, CLK_OUT_EN); end
    tick(2);
    n_chk++; if (CLK_OUT_EN !== 4'b0010) begin n_fail++; $display("FAIL rr_slot1 got %b exp 0010", CLK_OUT_EN); end
    tick(2);
    n_chk++; if (CLK_OUT_EN !== 4'b0110) begin n_fail++; $display("FAIL rr_slot2 got %b exp 0110", CLK_OUT_EN); end
    tick(4);
    n_chk++; if (STATE !== 3'd4 || READY !== 1'b1 || CLK_OUT_EN !== 4'b0110) begin n_fail++; $display("FAIL rr_run got st=%0d rdy=%0b en=%b exp 4 1 0110", STATE, READY, CLK_OUT_EN); end
    OUT_EN_MASK = 4'b1001;
    tick(3);
    n_chk++; if (STATE !== 3'd4 || CLK_OUT_EN !== 4'b0110) begin n_fail++; $display("FAIL rr_mask_ignored got st=%0d en=%b exp 4 0110", STATE, CLK_OUT_EN); end
    RST = 1'b1;
    tick(1);
    n_chk++; if (STATE !== 3'd0 || PLL_EN !== 1'b0 || CLK_OUT_EN !== 4'b0000 || READY !== 1'b0 || FAULT !== 1'b0 || RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL rr_reset got st=%0d en=%0b oe=%b rdy=%0b flt=%0b rc=%0d exp all 0", STATE, PLL_EN, CLK_OUT_EN, READY, FAULT, RETRY_CNT); end
    RST = 1'b0;
    tick(11);
    n_chk++; if (STATE !== 3'd3 || CLK_OUT_EN !== 4'b0001) begin n_fail++; $display("FAIL rr_new_mask got st=%0d en=%b exp 3 0001", STATE, CLK_OUT_EN); end
    OUT_EN_MASK = 4'b0110;
    tick(6);
    n_chk++; if (CLK_OUT_EN !== 4'b1001) begin n_fail++; $display("FAIL rr_new_mask_slot3 got %b exp 1001", CLK_OUT_EN); end
    tick(2);
    n_chk++; if (STATE !== 3'd4 || READY !== 1'b1) begin n_fail++; $display("FAIL rr_rerun got st=%0d rdy=%0b exp 4 1", STATE, READY); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_run();
    test_glitch_stable();
    test_abort_enable();
    test_timeout_fault();
    test_reset_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
